// File: rtl/lfsr_checker_if.sv
// lfsr_checker_if: bit-stream and status bundle for the PRBS checker.
//   master : stream source / status consumer (drives bit_en, bit_in, clr_err)
//   slave  : the checker (drives locked, err_pulse, sync_loss, wrap_tick,
//            err_count, shadow)
interface lfsr_checker_if #(
    parameter int ERR_CNT_W = 16
) ();
    logic                 bit_en;
    logic                 bit_in;
    logic                 clr_err;
    logic                 locked;
    logic                 err_pulse;
    logic                 sync_loss;
    logic                 wrap_tick;
    logic [ERR_CNT_W-1:0] err_count;
    logic [11:0]          shadow;

    modport master (
        output bit_en, bit_in, clr_err,
        input  locked, err_pulse, sync_loss, wrap_tick, err_count, shadow
    );

    modport slave (
        input  bit_en, bit_in, clr_err,
        output locked, err_pulse, sync_loss, wrap_tick, err_count, shadow
    );
endinterface

// File: rtl/lfsr_checker.sv
// lfsr_checker: receive-side checker for the 12-bit XNOR PRBS (taps 12,6,4,1).
// A shadow LFSR is filled from the incoming stream (HUNT), confirmed against
// its own predictions for VERIFY_BITS bits (VERIFY), then free-runs (LOCKED)
// comparing each received bit with the prediction.
// Ports:
//   CCLK   : clock, posedge
//   rst_n  : synchronous active-low reset
//   bus    : lfsr_checker_if.slave
//            in : bit_en (qualifier), bit_in (PRBS bit), clr_err
//            out: locked, err_pulse, sync_loss, wrap_tick, err_count, shadow
// All outputs are registered and reflect the bit sampled on the previous edge.
module lfsr_checker #(
    parameter int SEED_W         = 12,
    parameter int VERIFY_BITS    = 12,
    parameter int SYNC_ERR_LIMIT = 4,
    parameter int ERR_CNT_W      = 16
) (
    input  logic          CCLK,
    input  logic          rst_n,
    lfsr_checker_if.slave bus
);

    typedef enum logic [1:0] {HUNT, VERIFY, LOCKED} state_t;

    localparam logic [7:0]          VERIFY_CNT  = 8'(VERIFY_BITS);
    localparam logic [3:0]          CONSEC_MAX  = 4'(SYNC_ERR_LIMIT);
    localparam logic [3:0]          FILL_FULL   = 4'd12;
    localparam logic [11:0]         PERIOD_LAST = 12'd4094;
    localparam logic [SEED_W-1:0]   LOCKUP      = '1;
    localparam logic [ERR_CNT_W-1:0] ERR_ONE    = ERR_CNT_W'(1);

    state_t               state_q, state_d;
    logic [SEED_W-1:0]    s_q, s_d;
    logic [3:0]           fill_q, fill_d;
    logic [7:0]           vcnt_q, vcnt_d;
    logic [3:0]           consec_q, consec_d;
    logic [11:0]          period_q, period_d;
    logic [ERR_CNT_W-1:0] err_q, err_d;
    logic                 locked_q;
    logic                 ep_q, ep_d;
    logic                 sl_q, sl_d;
    logic                 wt_q, wt_d;

    logic                 pred;
    logic [SEED_W-1:0]    s_shift;

    // XNOR feedback: the bit the generator will shift in next.
    assign pred    = ~(s_q[11] ^ s_q[5] ^ s_q[3] ^ s_q[0]);
    assign s_shift = {s_q[SEED_W-2:0], bus.bit_in};

    always_ff @(posedge CCLK) begin
        if (!rst_n) begin
            state_q  <= HUNT;
            s_q      <= '0;
            fill_q   <= '0;
            vcnt_q   <= '0;
            consec_q <= '0;
            period_q <= '0;
            err_q    <= '0;
            locked_q <= 1'b0;
            ep_q     <= 1'b0;
            sl_q     <= 1'b0;
            wt_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            s_q      <= s_d;
            fill_q   <= fill_d;
            vcnt_q   <= vcnt_d;
            consec_q <= consec_d;
            period_q <= period_d;
            err_q    <= err_d;
            locked_q <= (state_d == LOCKED);
            ep_q     <= ep_d;
            sl_q     <= sl_d;
            wt_q     <= wt_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        s_d      = s_q;
        fill_d   = fill_q;
        vcnt_d   = vcnt_q;
        consec_d = consec_q;
        period_d = period_q;
        ep_d     = 1'b0;
        sl_d     = 1'b0;
        wt_d     = 1'b0;

        if (bus.bit_en) begin
            case (state_q)
                HUNT: begin
                    s_d    = s_shift;
                    fill_d = (fill_q == FILL_FULL) ? FILL_FULL : fill_q + 4'd1;
                    // All-ones is the XNOR lock-up state; never verify from it.
                    if (fill_d == FILL_FULL && s_shift != LOCKUP) begin
                        state_d = VERIFY;
                        vcnt_d  = '0;
                    end
                end
                VERIFY: begin
                    s_d = s_shift;
                    if (bus.bit_in == pred) begin
                        vcnt_d = vcnt_q + 8'd1;
                        if (vcnt_d == VERIFY_CNT) begin
                            state_d  = LOCKED;
                            period_d = '0;
                            consec_d = '0;
                        end
                    end else begin
                        state_d = HUNT;
                        fill_d  = '0;
                    end
                end
                LOCKED: begin
                    // Flywheel: only the prediction is shifted in, so a bad
                    // received bit cannot corrupt later predictions.
                    s_d = {s_q[SEED_W-2:0], pred};
                    if (period_q == PERIOD_LAST) begin
                        wt_d     = 1'b1;
                        period_d = '0;
                    end else begin
                        period_d = period_q + 12'd1;
                    end
                    if (bus.bit_in != pred) begin
                        ep_d     = 1'b1;
                        consec_d = consec_q + 4'd1;
                        if (consec_d == CONSEC_MAX) begin
                            sl_d     = 1'b1;
                            state_d  = HUNT;
                            fill_d   = '0;
                            consec_d = '0;
                        end
                    end else begin
                        consec_d = '0;
                    end
                end
                default: begin
                    state_d = HUNT;
                    fill_d  = '0;
                end
            endcase
        end
    end

    // Clear wins over the old value but never swallows a same-cycle error.
    always_comb begin
        err_d = err_q;
        if (bus.clr_err)
            err_d = ep_d ? ERR_ONE : '0;
        else if (ep_d && err_q != '1)
            err_d = err_q + ERR_ONE;
    end

    assign bus.locked    = locked_q;
    assign bus.err_pulse = ep_q;
    assign bus.sync_loss = sl_q;
    assign bus.wrap_tick = wt_q;
    assign bus.err_count = err_q;
    assign bus.shadow    = s_q;

endmodule

// File: tb/tb_lfsr_checker.sv
module tb_lfsr_checker;

    localparam logic [11:0] SEED = 12'b001101100111;

    logic CCLK = 1'b0;
    logic rst_n, bit_en, bit_in, clr_err;

    always #5 CCLK = ~CCLK;

    lfsr_checker_if #(.ERR_CNT_W(16)) bus  ();
    lfsr_checker_if #(.ERR_CNT_W(4))  bus4 ();

    assign bus.bit_en   = bit_en;
    assign bus.bit_in   = bit_in;
    assign bus.clr_err  = clr_err;
    assign bus4.bit_en  = bit_en;
    assign bus4.bit_in  = bit_in;
    assign bus4.clr_err = clr_err;

    lfsr_checker #(.ERR_CNT_W(16)) dut  (.CCLK(CCLK), .rst_n(rst_n), .bus(bus.slave));
    lfsr_checker #(.ERR_CNT_W(4))  dut4 (.CCLK(CCLK), .rst_n(rst_n), .bus(bus4.slave));

    int n_cmp = 0;
    int n_fail = 0;
    int n_ep, n_wt, n_sl, lbit;
    int tk[2];
    logic [11:0] g, rx;

    typedef struct {
        logic        rst_n, en, b, clr;
        logic        locked, ep;
        logic [11:0] sh;
        logic [15:0] ec;
    } vec_t;
    vec_t tbl[11];

    function automatic logic [11:0] gen_next(input logic [11:0] s);
        return {s[10:0], ~(s[11] ^ s[5] ^ s[3] ^ s[0])};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step(input logic en, input logic b, input logic clr);
        bit_en  = en;
        bit_in  = b;
        clr_err = clr;
        @(posedge CCLK);
        #1;
        if (en && rst_n) lbit++;
        if (bus.err_pulse) n_ep++;
        if (bus.sync_loss) n_sl++;
        if (bus.wrap_tick) begin
            if (n_wt < 2) tk[n_wt] = lbit;
            n_wt++;
        end
    endtask

    // Next generator bit, optionally inverted on the wire.
    task automatic send(input logic inv, input logic clr);
        g = gen_next(g);
        step(1'b1, g[0] ^ inv, clr);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step(1'($urandom_range(1)), 1'($urandom_range(1)), 1'b0);
            chk("reset_outputs",
                {bus.locked, bus.err_pulse, bus.sync_loss, bus.wrap_tick, bus.shadow, bus.err_count},
                64'h0);
        end
        rst_n = 1'b1;
    endtask

    // Lock from SEED with clean bits; checks locked edge on bit 24.
    task automatic lock_clean(input string name);
        g = SEED;
        for (int i = 1; i <= 24; i++) begin
            send(1'b0, 1'b0);
            if (i == 23) chk({name, "_not_yet"}, bus.locked, 1'b0);
            if (i == 24) chk({name, "_locked"}, bus.locked, 1'b1);
        end
    endtask

    initial begin
        rst_n = 1'b0; bit_en = 1'b0; bit_in = 1'b0; clr_err = 1'b0;
        n_ep = 0; n_wt = 0; n_sl = 0; lbit = 0;
        tk[0] = 0; tk[1] = 0;

        // rst, en, b, clr | locked, ep, shadow, err_count
        tbl[0]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 12'h000, 16'h0};
        tbl[1]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 12'h000, 16'h0};
        tbl[2]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 12'h000, 16'h0};
        tbl[3]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 12'h001, 16'h0};
        tbl[4]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 12'h001, 16'h0};
        tbl[5]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 12'h002, 16'h0};
        tbl[6]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 12'h005, 16'h0};
        tbl[7]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 12'h005, 16'h0};
        tbl[8]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 12'h00B, 16'h0};
        tbl[9]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 12'h017, 16'h0};
        tbl[10] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 12'h000, 16'h0};

        // Reset and early HUNT fill, table-driven.
        for (int i = 0; i < 11; i++) begin
            rst_n = tbl[i].rst_n;
            step(tbl[i].en, tbl[i].b, tbl[i].clr);
            chk($sformatf("vec%0d", i),
                {bus.locked, bus.err_pulse, bus.sync_loss, bus.wrap_tick, bus.shadow, bus.err_count},
                {tbl[i].locked, tbl[i].ep, 1'b0, 1'b0, tbl[i].sh, tbl[i].ec});
        end

        // Clean lock and two full PRBS periods.
        do_reset();
        lock_clean("clean");
        chk("clean_shadow", bus.shadow, g);
        n_ep = 0; n_wt = 0; lbit = 0;
        for (int i = 0; i < 8190; i++) send(1'b0, 1'b0);
        chk("period_err_pulses", n_ep, 0);
        chk("period_ticks", n_wt, 2);
        chk("tick1_pos", tk[0], 4095);
        chk("tick2_pos", tk[1], 8190);
        chk("period_shadow", bus.shadow, g);

        // Single error while locked.
        send(1'b1, 1'b0);
        chk("single_pulse", {bus.err_pulse, bus.locked, bus.sync_loss}, 3'b110);
        chk("single_count", bus.err_count, 16'd1);
        chk("single_flywheel", bus.shadow, g);
        n_ep = 0;
        for (int i = 0; i < 100; i++) send(1'b0, 1'b0);
        chk("after_single_pulses", n_ep, 0);
        chk("after_single_count", bus.err_count, 16'd1);

        // Burst of four errors forces sync loss, then relock.
        step(1'b0, 1'b0, 1'b1);
        chk("clr_idle", bus.err_count, 16'd0);
        for (int k = 0; k < 4; k++) begin
            send(1'b1, 1'b0);
            chk($sformatf("burst%0d", k), {bus.err_pulse, bus.sync_loss, bus.locked},
                {1'b1, (k == 3), (k != 3)});
        end
        chk("burst_count", bus.err_count, 16'd4);
        for (int i = 1; i <= 24; i++) begin
            send(1'b0, 1'b0);
            if (i == 23) chk("relock_not_yet", bus.locked, 1'b0);
            if (i == 24) chk("relock", bus.locked, 1'b1);
        end

        // All-ones stream never locks.
        do_reset();
        n_lk_check: begin
            int n_lk;
            n_lk = 0;
            for (int i = 0; i < 100; i++) begin
                step(1'b1, 1'b1, 1'b0);
                if (bus.locked) n_lk++;
            end
            chk("ones_locked_cycles", n_lk, 0);
            chk("ones_shadow", bus.shadow, 12'hFFF);
        end

        // Gapped stream: shadow holds during bit_en=0.
        do_reset();
        g = SEED; rx = '0;
        for (int i = 1; i <= 24; i++) begin
            send(1'b0, 1'b0);
            rx = {rx[10:0], g[0]};
            chk($sformatf("gap_sh%0d", i), bus.shadow, rx);
            if (i == 23) chk("gap_not_yet", bus.locked, 1'b0);
            if (i == 24) chk("gap_locked", bus.locked, 1'b1);
            step(1'b0, 1'($urandom_range(1)), 1'b0);
            chk($sformatf("gap_hold%0d", i),
                {bus.shadow, bus.err_pulse, bus.sync_loss, bus.wrap_tick}, {rx, 3'b000});
        end

        // clr_err coincident with a mismatch keeps the new error.
        send(1'b1, 1'b0);
        chk("pre_clr_count", bus.err_count, 16'd1);
        send(1'b1, 1'b1);
        chk("clr_with_err", {bus.err_pulse, bus.err_count}, {1'b1, 16'd1});
        send(1'b0, 1'b0);
        chk("still_locked", bus.locked, 1'b1);

        // Reset dominates while locked, even with an error bit present.
        rst_n = 1'b0;
        send(1'b1, 1'b0);
        chk("rst_locked",
            {bus.locked, bus.err_pulse, bus.sync_loss, bus.wrap_tick, bus.shadow, bus.err_count},
            64'h0);
        chk("rst_locked_w4", {bus4.locked, bus4.err_count}, 5'h0);
        rst_n = 1'b1;

        // Saturation on the 4-bit counter instance.
        do_reset();
        lock_clean("sat");
        for (int k = 1; k <= 20; k++) begin
            send(1'b1, 1'b0);
            send(1'b0, 1'b0);
            if (k == 15) chk("sat_at15", bus4.err_count, 4'd15);
        end
        chk("sat_hold", bus4.err_count, 4'd15);
        chk("sat_wide", bus.err_count, 16'd20);
        chk("sat_locked", {bus.locked, bus4.locked}, 2'b11);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
